// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizes rxd, reassembles frames LSB first and holds
// each byte in a one-entry register until acknowledged; framing/overrun flags are sticky.
module uart_rx #(
  parameter int CLK_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  input  logic       rd,
  input  logic       err_clr,
  output logic [7:0] rdata,
  output logic       rx_valid,
  output logic       ferr,
  output logic       ovf
);

  // state     | meaning
  // WAIT_HIGH | after reset or framing error; wait until the line is idle high
  // IDLE      | line idle, looking for a start edge
  // START     | counting to mid start bit to confirm it is not a glitch
  // DATA      | sampling 8 data bits at mid-bit, LSB first
  // STOP      | sampling the stop bit; deliver the byte or flag a framing error
  localparam logic [2:0] WAIT_HIGH = 3'd0;
  localparam logic [2:0] IDLE      = 3'd1;
  localparam logic [2:0] START     = 3'd2;
  localparam logic [2:0] DATA      = 3'd3;
  localparam logic [2:0] STOP      = 3'd4;

  localparam int CW = $clog2(CLK_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLK_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLK_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic          rx_meta;
  logic          rxs;
  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    sh;
  logic          stop_hit;
  logic          deliver;
  logic          frame_bad;

  // Synchronizer flops reset high so a reset never looks like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rxs     <= rx_meta;
    end
  end

  always_comb begin
    stop_hit  = (state == STOP) && (cnt == FULL_M1);
    deliver   = stop_hit && rxs;
    frame_bad = stop_hit && !rxs;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= WAIT_HIGH;
      cnt   <= '0;
      idx   <= '0;
      sh    <= '0;
    end else begin
      case (state)
        WAIT_HIGH: begin
          if (rxs) state <= IDLE;
        end
        IDLE: begin
          if (!rxs) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: begin
          if (cnt == HALF_M1) begin
            if (rxs) begin
              state <= IDLE;
            end else begin
              state <= DATA;
              cnt   <= '0;
              idx   <= '0;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        DATA: begin
          if (cnt == FULL_M1) begin
            sh  <= {rxs, sh[7:1]};
            cnt <= '0;
            if (idx == 3'd7) state <= STOP;
            else             idx   <= idx + 3'd1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        STOP: begin
          if (cnt == FULL_M1) begin
            cnt   <= '0;
            // Returning at mid-stop-bit leaves half a bit to catch a back-to-back start.
            state <= rxs ? IDLE : WAIT_HIGH;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: state <= WAIT_HIGH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata    <= 8'h00;
      rx_valid <= 1'b0;
      ferr     <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      if (deliver) begin
        if (!rx_valid || rd) begin
          rdata    <= sh;
          rx_valid <= 1'b1;
        end
      end else if (rd && rx_valid) begin
        rx_valid <= 1'b0;
      end

      // Set events take priority over a simultaneous clear.
      if (frame_bad)    ferr <= 1'b1;
      else if (err_clr) ferr <= 1'b0;

      if (deliver && rx_valid && !rd) ovf <= 1'b1;
      else if (err_clr)               ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit; expected values are hand-computed.
module tb_uart_rx;

  logic       clk;
  logic       rst;
  logic       rxd;
  logic       rd;
  logic       err_clr;
  logic [7:0] rdata;
  logic       rx_valid;
  logic       ferr;
  logic       ovf;

  int n_cmp = 0;
  int n_err = 0;

  uart_rx #(.CLK_PER_BIT(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .rxd      (rxd),
    .rd       (rd),
    .err_clr  (err_clr),
    .rdata    (rdata),
    .rx_valid (rx_valid),
    .ferr     (ferr),
    .ovf      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", tag, obs, exp);
    end
  endtask

  // Drives one full 10-bit frame, 16 cycles per bit; leaves rxd at the stop level.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    rxd = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      repeat (16) @(negedge clk);
    end
    rxd = stop_bit;
    repeat (16) @(negedge clk);
  endtask

  task automatic pulse_rd();
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rxd = 1'b1; rd = 1'b0; err_clr = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_rdata", rdata, 8'h00);
    check_eq("rst_valid", {7'd0, rx_valid}, 8'd0);
    check_eq("rst_ferr",  {7'd0, ferr}, 8'd0);
    check_eq("rst_ovf",   {7'd0, ovf}, 8'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Reset in the middle of data bit 3 of a 0xF0 frame.
    rxd = 1'b0;
    repeat (16 + 48 + 8) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_eq("midrst_valid", {7'd0, rx_valid}, 8'd0);
    check_eq("midrst_rdata", rdata, 8'h00);
    repeat (6) @(negedge clk);
    rxd = 1'b1;
    repeat (16 * 5 + 20) @(negedge clk);
    check_eq("midrst_nodeliv", {7'd0, rx_valid}, 8'd0);
    check_eq("midrst_ferr", {7'd0, ferr}, 8'd0);
    send_frame(8'h5A, 1'b1);
    check_eq("after_rst_valid", {7'd0, rx_valid}, 8'd1);
    check_eq("after_rst_rdata", rdata, 8'h5A);
    pulse_rd();
    repeat (10) @(negedge clk);

    // Basic frame with exact delivery latency: 2 sync + 8 + 144 + 1 = 155 edges.
    fork
      send_frame(8'hA5, 1'b1);
      begin
        repeat (154) @(posedge clk);
        @(negedge clk);
        check_eq("lat_valid_early", {7'd0, rx_valid}, 8'd0);
        @(posedge clk);
        @(negedge clk);
        check_eq("lat_valid_on", {7'd0, rx_valid}, 8'd1);
        check_eq("lat_rdata", rdata, 8'hA5);
      end
    join
    pulse_rd();
    check_eq("consume_valid", {7'd0, rx_valid}, 8'd0);
    check_eq("consume_rdata", rdata, 8'hA5);
    pulse_rd();
    check_eq("rd_idle_valid", {7'd0, rx_valid}, 8'd0);
    repeat (5) @(negedge clk);

    // Glitch shorter than half a bit.
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    rxd = 1'b1;
    repeat (40) @(negedge clk);
    check_eq("glitch_valid", {7'd0, rx_valid}, 8'd0);
    send_frame(8'h3C, 1'b1);
    check_eq("post_glitch_rdata", rdata, 8'h3C);
    check_eq("post_glitch_valid", {7'd0, rx_valid}, 8'd1);
    pulse_rd();
    repeat (5) @(negedge clk);

    // Framing error followed by a held-low line.
    send_frame(8'h55, 1'b0);
    repeat (40) @(negedge clk);
    check_eq("ferr_set", {7'd0, ferr}, 8'd1);
    check_eq("ferr_valid", {7'd0, rx_valid}, 8'd0);
    check_eq("ferr_rdata", rdata, 8'h3C);
    rxd = 1'b1;
    repeat (5) @(negedge clk);
    send_frame(8'h81, 1'b1);
    check_eq("rearm_rdata", rdata, 8'h81);
    check_eq("rearm_valid", {7'd0, rx_valid}, 8'd1);
    check_eq("ferr_sticky", {7'd0, ferr}, 8'd1);
    pulse_err_clr();
    check_eq("ferr_clr", {7'd0, ferr}, 8'd0);
    pulse_rd();
    repeat (5) @(negedge clk);

    // Overrun: second back-to-back byte dropped.
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    check_eq("ovr_rdata", rdata, 8'h11);
    check_eq("ovr_valid", {7'd0, rx_valid}, 8'd1);
    check_eq("ovr_ovf", {7'd0, ovf}, 8'd1);

    // Consume on delivery: rd coincides with the second stop-sample edge.
    pulse_rd();
    pulse_err_clr();
    check_eq("ovf_clr", {7'd0, ovf}, 8'd0);
    repeat (5) @(negedge clk);
    send_frame(8'h11, 1'b1);
    check_eq("cod_first_rdata", rdata, 8'h11);
    fork
      send_frame(8'h22, 1'b1);
      begin
        repeat (154) @(posedge clk);
        @(negedge clk);
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
      end
    join
    check_eq("cod_rdata", rdata, 8'h22);
    check_eq("cod_valid", {7'd0, rx_valid}, 8'd1);
    check_eq("cod_ovf", {7'd0, ovf}, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
